// File: rtl/width_split.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// width_split
// Wide-to-narrow serializer. Each accepted DSIZE*NSIZE-bit word is emitted as
// up to NSIZE lanes of DSIZE bits each, most-significant lane first. A word can
// carry fewer than NSIZE valid lanes. When this block feeds width_combin, the
// original words come back unchanged.
//
// Ports
//   clock          rising-edge clock
//   rst            asynchronous, active-high reset
//   wr_data        wide input word
//   wr_len         valid lanes in wr_data, counted from the MSB lane
//                  (0 or >NSIZE means NSIZE)
//   wr_vld         wr_data / wr_len / wr_last are valid
//   wr_ready       a word can be accepted this cycle (combinational on rd_ready)
//   wr_last        this word ends the packet
//   rd_data        current lane
//   rd_vld         rd_data is valid
//   rd_ready       downstream accepts the lane
//   rd_last        final lane of the final word of a packet
//   rd_align_last  final lane of every word
// -----------------------------------------------------------------------------
module width_split #(
    parameter  int DSIZE = 1,
    parameter  int NSIZE = 8,
    localparam int LSIZE = $clog2(NSIZE + 1)
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [DSIZE*NSIZE-1:0] wr_data,
    input  logic [LSIZE-1:0]       wr_len,
    input  logic                   wr_vld,
    output logic                   wr_ready,
    input  logic                   wr_last,
    output logic [DSIZE-1:0]       rd_data,
    output logic                   rd_vld,
    input  logic                   rd_ready,
    output logic                   rd_last,
    output logic                   rd_align_last
);

    localparam int               WIDTH   = DSIZE * NSIZE;
    localparam logic [LSIZE-1:0] NSIZE_L = LSIZE'(NSIZE);
    localparam logic [LSIZE-1:0] ONE_L   = LSIZE'(1);

    logic [WIDTH-1:0] shift_q;     // current lane always sits in the top DSIZE bits
    logic [LSIZE-1:0] point_q;     // index of the lane being presented
    logic [LSIZE-1:0] len_q;       // valid lanes in the word being emitted
    logic             vld_q;
    logic             pkt_last_q;  // captured wr_last of the word being emitted

    logic [LSIZE-1:0] wr_len_eff;
    logic             final_lane;
    logic             in_xfer;
    logic             out_xfer;

    // Zero or out-of-range lengths mean a full word.
    always_comb begin
        wr_len_eff = wr_len;
        if (wr_len == '0 || wr_len > NSIZE_L)
            wr_len_eff = NSIZE_L;
    end

    assign final_lane    = (point_q == len_q - ONE_L);
    assign rd_vld        = vld_q;
    assign rd_data       = shift_q[WIDTH-1 -: DSIZE];
    assign rd_align_last = vld_q & final_lane;
    assign rd_last       = rd_align_last & pkt_last_q;

    // A new word may enter when idle, or when the final lane leaves this very
    // cycle; the latter gives back-to-back words with no bubble. This path
    // depends only on rd_ready and local state, never on wr_vld, so chained
    // instances cannot form a combinational loop.
    assign wr_ready = ~rst & (~vld_q | (rd_ready & rd_align_last));

    assign in_xfer  = wr_vld & wr_ready;
    assign out_xfer = vld_q & rd_ready;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; the asynchronous reset branch comes first.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            point_q    <= '0;
            len_q      <= '0;
            vld_q      <= 1'b0;
            pkt_last_q <= 1'b0;
        end else if (in_xfer) begin
            shift_q    <= wr_data;
            len_q      <= wr_len_eff;
            point_q    <= '0;
            pkt_last_q <= wr_last;
            vld_q      <= 1'b1;
        end else if (out_xfer) begin
            if (final_lane) begin
                vld_q <= 1'b0;
            end else begin
                point_q <= point_q + ONE_L;
                shift_q <= shift_q << DSIZE;
            end
        end
    end

endmodule

// File: tb/tb_width_split.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_width_split
// Instance a: DSIZE=1, NSIZE=8 (bit-serial), directed scenarios checked against
// a lane-queue reference model. Instance b: DSIZE=2, NSIZE=4, random words and
// random rd_ready, with the lanes recombined into words by a reference combiner.
// -----------------------------------------------------------------------------
module tb_width_split;

    logic clock;
    logic rst;

    // instance a: DSIZE=1, NSIZE=8, LSIZE=4
    logic [7:0] a_wr_data;
    logic [3:0] a_wr_len;
    logic       a_wr_vld, a_wr_ready, a_wr_last;
    logic [0:0] a_rd_data;
    logic       a_rd_vld, a_rd_ready, a_rd_last, a_rd_align_last;

    // instance b: DSIZE=2, NSIZE=4, LSIZE=3
    logic [7:0] b_wr_data;
    logic [2:0] b_wr_len;
    logic       b_wr_vld, b_wr_ready, b_wr_last;
    logic [1:0] b_rd_data;
    logic       b_rd_vld, b_rd_ready, b_rd_last, b_rd_align_last;

    width_split #(.DSIZE(1), .NSIZE(8)) u_a (
        .clock(clock), .rst(rst),
        .wr_data(a_wr_data), .wr_len(a_wr_len), .wr_vld(a_wr_vld),
        .wr_ready(a_wr_ready), .wr_last(a_wr_last),
        .rd_data(a_rd_data), .rd_vld(a_rd_vld), .rd_ready(a_rd_ready),
        .rd_last(a_rd_last), .rd_align_last(a_rd_align_last)
    );

    width_split #(.DSIZE(2), .NSIZE(4)) u_b (
        .clock(clock), .rst(rst),
        .wr_data(b_wr_data), .wr_len(b_wr_len), .wr_vld(b_wr_vld),
        .wr_ready(b_wr_ready), .wr_last(b_wr_last),
        .rd_data(b_rd_data), .rd_vld(b_rd_vld), .rd_ready(b_rd_ready),
        .rd_last(b_rd_last), .rd_align_last(b_rd_align_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model for instance a ----------------
    typedef struct {
        logic d;
        logic align;
        logic last;
    } lane_t;

    lane_t a_q[$];       // lanes still to be emitted
    lane_t a_log[$];     // lanes actually transferred
    int    a_log_cyc[$]; // cycle number of each transferred lane
    int    cyc = 0;

    task automatic a_push(input logic [7:0] word, input int len, input logic last);
        int n;
        lane_t l;
        n = (len == 0 || len > 8) ? 8 : len;
        for (int k = 0; k < n; k++) begin
            l.d     = word[7-k];
            l.align = (k == n - 1);
            l.last  = (k == n - 1) && last;
            a_q.push_back(l);
        end
    endtask

    task automatic a_mon();
        logic exp_ready;
        logic in_x, out_x;
        lane_t l;
        if (rst) begin
            check("a_rst_vld",   a_rd_vld, 0);
            check("a_rst_data",  a_rd_data, 0);
            check("a_rst_last",  a_rd_last, 0);
            check("a_rst_align", a_rd_align_last, 0);
            check("a_rst_ready", a_wr_ready, 0);
            a_q.delete();
            return;
        end
        check("a_vld", a_rd_vld, a_q.size() != 0);
        if (a_q.size() != 0 && a_rd_vld) begin
            check("a_data",  a_rd_data, a_q[0].d);
            check("a_align", a_rd_align_last, a_q[0].align);
            check("a_last",  a_rd_last, a_q[0].last);
        end
        exp_ready = (a_q.size() == 0) || (a_rd_ready && a_q[0].align);
        check("a_wr_ready", a_wr_ready, exp_ready);
        out_x = a_rd_vld & a_rd_ready;
        in_x  = a_wr_vld & a_wr_ready;
        if (out_x && a_q.size() != 0) begin
            l.d = a_rd_data[0]; l.align = a_rd_align_last; l.last = a_rd_last;
            a_log.push_back(l);
            a_log_cyc.push_back(cyc);
            void'(a_q.pop_front());
        end
        if (in_x) a_push(a_wr_data, int'(a_wr_len), a_wr_last);
    endtask

    // ---------------- reference combiner for instance b ----------------
    typedef struct {
        logic [7:0] w;
        int         n;
        logic       last;
    } word_t;

    word_t      b_src[$];
    logic [7:0] b_acc = '0;
    int         b_k = 0;
    int         b_words = 0;

    task automatic b_mon();
        logic       fin;
        logic [7:0] m;
        word_t      s;
        if (rst) begin
            b_src.delete();
            b_k = 0;
            b_acc = '0;
            return;
        end
        check("b_vld", b_rd_vld, b_src.size() != 0);
        if (b_rd_vld && b_rd_ready && b_src.size() != 0) begin
            if (b_k < 4) b_acc = b_acc | (8'(b_rd_data) << (2 * (3 - b_k)));
            fin = (b_k == b_src[0].n - 1);
            check("b_align", b_rd_align_last, fin);
            check("b_last",  b_rd_last, fin & b_src[0].last);
            b_k++;
            if (fin) begin
                m = 8'hFF;
                m = m << (2 * (4 - b_src[0].n));
                check("b_word", b_acc, b_src[0].w & m);
                b_words++;
                void'(b_src.pop_front());
                b_k = 0;
                b_acc = '0;
            end
        end
        if (b_wr_vld && b_wr_ready) begin
            s.w    = b_wr_data;
            s.n    = (b_wr_len == 0 || b_wr_len > 4) ? 4 : int'(b_wr_len);
            s.last = b_wr_last;
            b_src.push_back(s);
        end
    endtask

    // Monitor: inputs change on the falling edge, outputs are sampled 2 ns later.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            cyc++;
            a_mon();
            b_mon();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

    // ---------------- drivers (all tasks start and end at a falling edge) ----------------
    task automatic a_send(input logic [7:0] word, input logic [3:0] len, input logic last);
        logic rdy, sent;
        a_wr_data = word; a_wr_len = len; a_wr_last = last; a_wr_vld = 1'b1;
        sent = 1'b0;
        for (int t = 0; t < 100 && !sent; t++) begin
            #1 rdy = a_wr_ready;
            @(negedge clock);
            sent = rdy;
        end
        a_wr_vld = 1'b0;
        check("a_send_accepted", sent, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Compare the logged lanes with n expected bits (right-aligned, first lane
    // in bit n-1). Word boundaries fall every 8 lanes or at the end.
    task automatic a_check_log(input string tag, input logic [15:0] bits, input int n,
                               input logic last_at_end, input logic contig);
        check({tag, "_count"}, a_log.size(), n);
        for (int i = 0; i < n && i < a_log.size(); i++) begin
            check($sformatf("%s_d%0d", tag, i), a_log[i].d, bits[n-1-i]);
            check($sformatf("%s_al%0d", tag, i), a_log[i].align, (i == n - 1) || (i % 8 == 7));
            check($sformatf("%s_la%0d", tag, i), a_log[i].last, (i == n - 1) && last_at_end);
            if (contig)
                check($sformatf("%s_cyc%0d", tag, i), a_log_cyc[i] - a_log_cyc[0], i);
        end
    endtask

    initial begin
        logic rdy, sent;
        rst = 1'b1;
        a_wr_data = '0; a_wr_len = '0; a_wr_vld = 1'b0; a_wr_last = 1'b0; a_rd_ready = 1'b1;
        b_wr_data = '0; b_wr_len = '0; b_wr_vld = 1'b0; b_wr_last = 1'b0; b_rd_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Full word, default length, not packet-last.
        a_log.delete(); a_log_cyc.delete();
        a_send(8'hA5, 4'd0, 1'b0);
        idle(10);
        a_check_log("a5", 16'h00A5, 8, 1'b0, 1'b1);

        // Back-to-back words, second one ends the packet.
        a_log.delete(); a_log_cyc.delete();
        a_send(8'h3C, 4'd0, 1'b0);
        a_send(8'hFF, 4'd0, 1'b1);
        idle(20);
        a_check_log("b2b", 16'h3CFF, 16, 1'b1, 1'b1);

        // Backpressure on the fourth lane.
        a_log.delete(); a_log_cyc.delete();
        a_send(8'hA5, 4'd0, 1'b0);
        idle(3);
        a_rd_ready = 1'b0;
        repeat (3) begin
            #2;
            check("bp_data",  a_rd_data, 0);
            check("bp_vld",   a_rd_vld, 1);
            check("bp_ready", a_wr_ready, 0);
            @(negedge clock);
        end
        a_rd_ready = 1'b1;
        idle(10);
        a_check_log("bp", 16'h00A5, 8, 1'b0, 1'b0);

        // Short final word: three lanes.
        a_log.delete(); a_log_cyc.delete();
        a_send(8'hE0, 4'd3, 1'b1);
        idle(3);
        #2 check("short_vld_after", a_rd_vld, 0);
        idle(3);
        a_check_log("short", 16'h0007, 3, 1'b1, 1'b1);

        // Reset in the middle of a word.
        a_send(8'hA5, 4'd0, 1'b0);
        idle(4);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_vld",   a_rd_vld, 0);
        check("mid_rst_data",  a_rd_data, 0);
        check("mid_rst_last",  a_rd_last, 0);
        check("mid_rst_align", a_rd_align_last, 0);
        check("mid_rst_ready", a_wr_ready, 0);
        @(negedge clock);
        rst = 1'b0;
        a_log.delete(); a_log_cyc.delete();
        idle(2);
        a_send(8'h81, 4'd0, 1'b0);
        idle(10);
        a_check_log("post_rst", 16'h0081, 8, 1'b0, 1'b1);

        // Random round trip on instance b.
        for (int w = 0; w < 200; w++) begin
            repeat ($urandom_range(0, 2)) begin
                b_rd_ready = ($urandom_range(0, 3) != 0);
                @(negedge clock);
            end
            b_wr_data = 8'($urandom);
            b_wr_len  = 3'($urandom_range(0, 7));
            b_wr_last = 1'($urandom_range(0, 1));
            b_wr_vld  = 1'b1;
            sent = 1'b0;
            for (int t = 0; t < 200 && !sent; t++) begin
                b_rd_ready = ($urandom_range(0, 3) != 0);
                #1 rdy = b_wr_ready;
                @(negedge clock);
                sent = rdy;
            end
            b_wr_vld = 1'b0;
            check("b_send_accepted", sent, 1);
        end
        b_rd_ready = 1'b1;
        for (int t = 0; t < 50 && b_src.size() != 0; t++) @(negedge clock);
        #3;
        check("b_drained", b_src.size(), 0);
        check("b_word_count", b_words, 200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
